// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the CPU memory port and the debug/loader port.
// It owns the shared memory bus and runs one fixed-length strobe access at a time.
module mem_bus_arbiter #(
  parameter int WIDTH   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_ack,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic             dbg_ack,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_re_L,
  output logic             mem_we_L,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic       PORT_CPU = 1'b0;
  localparam logic       PORT_DBG = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               owner_q, owner_d;
  logic               last_gnt_q, last_gnt_d;
  logic               re_l_q, re_l_d;
  logic               we_l_q, we_l_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               dbg_ack_q, dbg_ack_d;
  logic               grant_dbg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      owner_q    <= PORT_CPU;
      last_gnt_q <= PORT_DBG;
      re_l_q     <= 1'b1;
      we_l_q     <= 1'b1;
      cpu_ack_q  <= 1'b0;
      dbg_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      re_l_q     <= re_l_d;
      we_l_q     <= we_l_d;
      cpu_ack_q  <= cpu_ack_d;
      dbg_ack_q  <= dbg_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cpu_ack_d  = 1'b0;
    dbg_ack_d  = 1'b0;
    // Debug wins when alone, or on a tie when the CPU had the previous grant.
    grant_dbg  = dbg_req && (!cpu_req || (last_gnt_q == PORT_CPU));

    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d    = grant_dbg;
          last_gnt_d = grant_dbg;
          we_d       = grant_dbg ? dbg_we    : cpu_we;
          addr_d     = grant_dbg ? dbg_addr  : cpu_addr;
          wdata_d    = grant_dbg ? dbg_wdata : cpu_wdata;
          cnt_d      = CNT_LOAD;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          cpu_ack_d = (owner_q == PORT_CPU);
          dbg_ack_d = (owner_q == PORT_DBG);
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are registered so the memory sees clean edges aligned with ACCESS.
    re_l_d = !((state_d == ACCESS) && !we_d);
    we_l_d = !((state_d == ACCESS) && we_d);
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re_L  = re_l_q;
  assign mem_we_L  = we_l_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule
